// File: rtl/top_sr.sv
// top_sr: serial configuration controller for an external shift-register chain.
module top_sr #(
   parameter int WIDTH = 170
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [3:0]       div,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             dout_sr,
   output logic             clk_sr,
   output logic             din_sr,
   output logic             load_sr,
   output logic [WIDTH-1:0] dout
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
   state_t state, state_n;
   logic start_q, trig, bit_end, last_bit;
   logic clk_sr_n, din_sr_n, load_sr_n;
   logic [3:0] per, ph, half;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] tx, rx;
   assign trig = state == IDLE && start && !start_q;
   assign half = per >> 1;
   assign bit_end = ph == per - 4'd1;
   assign last_bit = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk_in)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = trig ? SHIFT :
                (state == SHIFT && bit_end && last_bit) ? LOAD :
                (state == LOAD && bit_end) ? IDLE : state;
   // Output values for the cycle the current phase describes; registered below.
   always_comb begin
      clk_sr_n = state == SHIFT && ph >= half;
      din_sr_n = state == SHIFT && tx[WIDTH-1];
      load_sr_n = state == LOAD;
   end
   always_ff @(posedge clk_in)
      if (rst) begin
         start_q <= 1'b0;
         clk_sr <= 1'b0;
         din_sr <= 1'b0;
         load_sr <= 1'b0;
         dout <= '0;
         tx <= '0;
         rx <= '0;
         per <= '0;
         ph <= '0;
         cnt <= '0;
      end else begin
         start_q <= start;
         clk_sr <= clk_sr_n;
         din_sr <= din_sr_n;
         load_sr <= load_sr_n;
         if (trig) begin
            tx <= din;
            rx <= '0;
            per <= div < 4'd2 ? 4'd2 : div;
            ph <= '0;
            cnt <= '0;
         end else if (state != IDLE) begin
            ph <= bit_end ? 4'd0 : ph + 4'd1;
            // Capture on the same edge that raises clk_sr.
            if (state == SHIFT && ph == half) rx <= {rx[WIDTH-2:0], dout_sr};
            if (state == SHIFT && bit_end) begin
               tx <= tx << 1;
               cnt <= cnt + 1'b1;
            end
            if (state == LOAD && bit_end) dout <= rx;
         end
      end
endmodule

// File: tb/tb_top_sr.sv
// tb_top_sr: table-driven, hand-written and randomized checks of top_sr
// against a cycle-indexed model of the serial waveform.
module tb_top_sr;
   localparam int W = 170;
   logic clk_in = 0, rst, start, dout_sr, clk_sr, din_sr, load_sr;
   logic [3:0] div;
   logic [W-1:0] din, dout, exp_dout;
   int checks = 0, errors = 0;

   top_sr #(.WIDTH(W)) dut (
      .clk_in(clk_in), .rst(rst), .div(div), .start(start), .din(din),
      .dout_sr(dout_sr), .clk_sr(clk_sr), .din_sr(din_sr), .load_sr(load_sr), .dout(dout)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0] dv;
      logic [W-1:0] d;
      logic [W-1:0] rb;
      logic [W-1:0] exp_dout;
      int exp_p;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic quiet(input int n, input string nm);
      int act = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk_in);
         @(posedge clk_in); #1;
         act += int'(clk_sr | din_sr | load_sr);
      end
      chk(nm, W'(act), '0);
   endtask

   // mode 0: start high 2 cycles; 1: extra start pulse mid-shift; 2: start held high.
   task automatic xfer(input logic [3:0] dv, input logic [W-1:0] d, input logic [W-1:0] rb,
                       input int mode, output int rises, output int loads);
      int p, n, bad, first, b, q;
      logic pc, ec, ed, el;
      logic [W-1:0] ed_out;
      p = dv < 2 ? 2 : int'(dv);
      n = W * p + p + 1;
      bad = 0; first = -1; rises = 0; loads = 0; pc = 0;
      @(negedge clk_in);
      div = dv; din = d; start = 1; dout_sr = 0;
      @(posedge clk_in);
      for (int k = 1; k <= n; k++) begin
         b = (k - 1) / p;
         q = (k - 1) % p;
         @(negedge clk_in);
         dout_sr = k <= W * p ? rb[W-1-b] : 1'b0;
         if (k == 2 && mode != 2) start = 0;
         if (k == 3) begin din = ~d; div = 4'($urandom_range(0, 15)); end
         if (mode == 1 && k == 10) start = 1;
         if (mode == 1 && k == 12) start = 0;
         @(posedge clk_in); #1;
         ec = k <= W * p && q >= p / 2;
         ed = k <= W * p && d[W-1-b];
         el = k > W * p && k <= W * p + p;
         ed_out = k >= W * p + p ? rb : exp_dout;
         if (clk_sr && !pc) rises++;
         pc = clk_sr;
         if (load_sr) loads++;
         if ({clk_sr, din_sr, load_sr} !== {ec, ed, el} || dout !== ed_out) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      if (bad != 0) $display("wave: first divergence at cycle %0d after trigger", first);
      chk("wave", W'(bad), '0);
      exp_dout = rb;
   endtask

   initial begin
      int r, l;
      logic [W-1:0] d, rb;
      logic [3:0] dv;
      rst = 1; start = 0; din = '0; div = '0; dout_sr = 0; exp_dout = '0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_out", W'({clk_sr, din_sr, load_sr}), '0);
      chk("reset_dout", dout, '0);
      @(negedge clk_in); rst = 0;

      tbl[0] = '{4'd2, {1'b1, 169'd11}, '0, '0, 2};
      tbl[1] = '{4'd2, {85{2'b10}}, 170'hF, 170'hF, 2};
      tbl[2] = '{4'd5, {85{2'b10}}, {85{2'b01}}, {85{2'b01}}, 5};
      tbl[3] = '{4'd0, 170'h123456789, 170'h3, 170'h3, 2};
      tbl[4] = '{4'd1, {W{1'b1}}, {1'b1, 169'd0}, {1'b1, 169'd0}, 2};
      tbl[5] = '{4'd15, 170'hDEADBEEF, 170'hCAFE, 170'hCAFE, 15};
      for (int i = 0; i < 6; i++) begin
         xfer(tbl[i].dv, tbl[i].d, tbl[i].rb, 0, r, l);
         chk("clk_pulses", W'(r), W'(W));
         chk("load_cycles", W'(l), W'(tbl[i].exp_p));
         chk("dout", dout, tbl[i].exp_dout);
      end

      // Reset while idle clears a non-zero readback.
      @(negedge clk_in); rst = 1;
      repeat (2) @(posedge clk_in);
      #1;
      chk("idle_rst_out", W'({clk_sr, din_sr, load_sr}), '0);
      chk("idle_rst_dout", dout, '0);
      @(negedge clk_in); rst = 0;
      exp_dout = '0;

      // Abort at bit 80, just before clk_sr would rise with din_sr=1.
      @(negedge clk_in);
      div = 2; din = '1; dout_sr = 1; start = 1;
      @(posedge clk_in);
      for (int k = 1; k <= 161; k++) begin
         @(negedge clk_in);
         if (k == 2) start = 0;
         @(posedge clk_in);
      end
      @(negedge clk_in); rst = 1;
      @(posedge clk_in); #1;
      chk("abort_out", W'({clk_sr, din_sr, load_sr}), '0);
      @(negedge clk_in); rst = 0; dout_sr = 0;
      quiet(400, "abort_quiet");
      chk("abort_dout", dout, '0);
      for (int i = 0; i < W; i++) begin d[i] = 1'($urandom_range(0, 1)); rb[i] = 1'($urandom_range(0, 1)); end
      xfer(4'd3, d, rb, 0, r, l);
      chk("after_abort_dout", dout, rb);

      // Start pulse during SHIFT is ignored.
      xfer(4'd2, {W{1'b1}}, 170'h5A5, 1, r, l);
      chk("busy_loads", W'(l), W'(2));
      quiet(30, "busy_tail");

      // Start held high triggers once.
      xfer(4'd4, 170'hF0F0, 170'h77, 2, r, l);
      quiet(40, "hold_tail");
      @(negedge clk_in); start = 0;

      for (int t = 0; t < 6; t++) begin
         dv = 4'($urandom_range(0, 9));
         for (int i = 0; i < W; i++) begin d[i] = 1'($urandom_range(0, 1)); rb[i] = 1'($urandom_range(0, 1)); end
         xfer(dv, d, rb, 0, r, l);
         chk("rand_dout", dout, rb);
         chk("rand_pulses", W'(r), W'(W));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/top_sr.md
Name: top_sr

Overview:
- Serial configuration controller for an external shift-register chain (WIDTH bits, default 170).
- On a start request it latches a parallel word and shifts it out MSB-first on din_sr with a generated serial clock clk_sr. At the same time it captures the chain's serial output dout_sr into a readback word.
- After the last bit it pulses load_sr to commit the chain, then presents the readback on dout.
- Sits between the system-side register bank (clk_in domain) and the off-chip/on-die configuration shift register.

Parameters:
- WIDTH, 170, number of bits in the shift chain (parallel din/dout width).

Ports:
- clk_in  input  1  system clock; all logic on rising edge. One clock only.
- rst  input  1  synchronous, active-high reset.
- div  input  4  serial bit-period select, in clk_in cycles; latched at start.
- start  input  1  transfer request; rising edge triggers.
- din  input  WIDTH  parallel word to shift out; latched at start.
- dout_sr  input  1  serial data returned from the chain.
- clk_sr  output  1  serial shift clock to the chain.
- din_sr  output  1  serial data to the chain.
- load_sr  output  1  load/latch strobe to the chain.
- dout  output  WIDTH  parallel readback word captured from dout_sr.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk_in edge):
  - clk_sr=0, din_sr=0, load_sr=0, dout=0.
  - Internal tx/rx registers and counters cleared.
  - FSM goes to IDLE and the start edge detector is cleared.
  - This applies mid-transfer too: the transfer is aborted and no load_sr is issued.
- Bit period P = div clk_in cycles when div>=2. div=0 or div=1 is treated as P=2.
- Each bit period: clk_sr low for L=floor(P/2) cycles, then high for H=P-L cycles.
- Start detection:
  - start is registered, and a rising edge (start=1, previous=0) seen in IDLE triggers a transfer.
  - In the same edge, latch din into tx, latch P, clear rx, bit count and phase count.
  - Start edges outside IDLE are ignored.
  - A start held high triggers only once.
- FSM states IDLE, SHIFT, LOAD:
- IDLE: clk_sr=0, din_sr=0, load_sr=0; dout holds its last value.
- SHIFT:
  - din_sr = tx[WIDTH-1] for the whole bit period; first bit appears the cycle after the trigger.
  - clk_sr rises after L cycles, which gives din_sr setup of L cycles.
  - On the clk_in edge that drives clk_sr 0->1, sample dout_sr: rx <= {rx[WIDTH-2:0], dout_sr}, MSB-first.
  - At the end of each bit period, tx shifts left by 1 (zero fill) and the bit count increments.
  - After WIDTH bits, go to LOAD.
- LOAD:
  - clk_sr=0, din_sr=0, load_sr=1 for exactly P cycles.
  - On exit, dout <= rx, then return to IDLE.
- Total transfer from trigger to IDLE = 1 + WIDTH*P + P cycles.
- dout updates only at LOAD exit. Partial captures are never visible, and an aborted transfer leaves dout at reset value 0.
- Changes on din/div during a transfer have no effect.

Test Plan:
- Reset: assert rst 2 cycles mid-idle -> clk_sr=0, din_sr=0, load_sr=0, dout=0.
- Basic shift:
  - Stimulus: div=2, din={1'b1,169'b1011}, start high 2 cycles, dout_sr=0.
  - Response: 170 clk_sr pulses, period 2 cycles (1 low/1 high).
  - din_sr sequence is 1, then 165 zeros, then 1,0,1,1.
  - load_sr high 2 cycles after the last clk_sr pulse; dout=0 after 343 cycles.
- Readback:
  - Stimulus: div=2, dout_sr=1 during the last 4 bit periods only, else 0.
  - Response: dout=170'hF (last 4 captured bits = 1).
- Divider:
  - Stimulus: div=5.
  - Response: clk_sr low 2, high 3 per bit; load_sr high 5 cycles; total 1+170*5+5 = 856 cycles.
  - Stimulus: div=0.
  - Response: behaves as div=2.
- Reset mid-transfer:
  - Stimulus: rst at bit 80.
  - Response: outputs 0 next cycle, no load_sr, dout stays 0; a new start afterwards completes normally.
- Start while busy:
  - Stimulus: second start pulse during SHIFT.
  - Response: ignored; exactly one load_sr pulse.
